// File: rtl/branch_redirect_if.sv
// branch_redirect_if: bundles the EX-stage branch info, the redirect
// request to fetch and the IF/ID flush / misalign pulses of branch_redirect.
// Modport master is the resolution unit; slave is the surrounding pipeline.
`ifndef XLEN
`define XLEN 32
`endif

interface branch_redirect_if #(
    parameter int XLEN = `XLEN
);
    logic            ex_valid;
    logic            ex_ready;
    logic            ex_is_branch;
    logic            ex_is_jal;
    logic            ex_is_jalr;
    logic [XLEN-1:0] ex_pc;
    logic [XLEN-1:0] ex_imm;
    logic [XLEN-1:0] ex_rs1;
    logic            br_taken;
    logic            pred_taken;
    logic [XLEN-1:0] pred_target;
    logic            redirect_valid;
    logic            redirect_ready;
    logic [XLEN-1:0] redirect_pc;
    logic            flush_o;
    logic            misalign_valid;
    logic [XLEN-1:0] misalign_addr;

    modport master (
        input  ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
        input  ex_pc, ex_imm, ex_rs1, br_taken, pred_taken, pred_target,
        input  redirect_ready,
        output ex_ready, redirect_valid, redirect_pc, flush_o,
        output misalign_valid, misalign_addr
    );

    modport slave (
        output ex_valid, ex_is_branch, ex_is_jal, ex_is_jalr,
        output ex_pc, ex_imm, ex_rs1, br_taken, pred_taken, pred_target,
        output redirect_ready,
        input  ex_ready, redirect_valid, redirect_pc, flush_o,
        input  misalign_valid, misalign_addr
    );
endinterface

// File: rtl/branch_redirect.sv
// branch_redirect: execute-stage branch resolution. Computes the correct
// next PC for branches/JAL/JALR, compares it with the fetch prediction and
// issues a held redirect request plus a one-cycle IF/ID flush on mispredict.
// Misaligned taken targets are reported as a one-cycle pulse instead.
// Optional: define BRANCH_REDIRECT_PERF_EN to add saturating 32-bit
// counters perf_br_cnt (accepted branches/jumps) and perf_mispred_cnt.
`ifndef XLEN
`define XLEN 32
`endif

module branch_redirect #(
    parameter int              XLEN     = `XLEN,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              kill_i,
    branch_redirect_if.master br
`ifdef BRANCH_REDIRECT_PERF_EN
    ,
    output logic [31:0]       perf_br_cnt,
    output logic [31:0]       perf_mispred_cnt
`endif
);

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic            ex_ready_p0;
    logic            is_cti_p0;
    logic            accept_p0;
    logic            taken_p0;
    logic            misalign_p0;
    logic            mispred_p0;
    logic [XLEN-1:0] jalr_sum_p0;
    logic [XLEN-1:0] target_p0;
    logic [XLEN-1:0] seq_pc_p0;
    logic [XLEN-1:0] correct_p0;

    logic            flush_p1;
    logic            vld_misalign_p1;
    logic [XLEN-1:0] redirect_pc_p1;
    logic [XLEN-1:0] misalign_addr_p1;

    // ---- stage p0: resolve the EX instruction combinationally ----
    // A pending redirect blocks EX unless it handshakes this same cycle.
    assign ex_ready_p0 = (state_q == IDLE) | br.redirect_ready;
    assign is_cti_p0   = br.ex_is_branch | br.ex_is_jal | br.ex_is_jalr;
    assign accept_p0   = br.ex_valid & ex_ready_p0 & is_cti_p0 & ~kill_i;

    // JALR clears bit 0 of the computed address; wrap-around is legal.
    assign jalr_sum_p0 = br.ex_rs1 + br.ex_imm;
    assign target_p0   = br.ex_is_jalr ? {jalr_sum_p0[XLEN-1:1], 1'b0}
                                       : br.ex_pc + br.ex_imm;
    assign seq_pc_p0   = br.ex_pc + XLEN'(4);

    assign taken_p0    = br.ex_is_jal | br.ex_is_jalr | (br.ex_is_branch & br.br_taken);
    assign correct_p0  = taken_p0 ? target_p0 : seq_pc_p0;

    // A misaligned taken target wins over any prediction comparison.
    assign misalign_p0 = taken_p0 & target_p0[1];
    assign mispred_p0  = ~misalign_p0 &
                         ((br.pred_taken != taken_p0) |
                          (taken_p0 & br.pred_taken & (br.pred_target != target_p0)));

    // Redirect-pending state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: kill first, then a new mispredict (which may reload PEND
    // in the handshake cycle), then completion of the pending handshake.
    always_comb begin
        state_d = state_q;
        if (kill_i) begin
            state_d = IDLE;
        end else if (accept_p0 && mispred_p0) begin
            state_d = PEND;
        end else if ((state_q == PEND) && br.redirect_ready) begin
            state_d = IDLE;
        end
    end

    // ---- stage p1: registered redirect / flush / misalign outputs ----
    // Flush and misalign are single-cycle pulses; addresses hold until reloaded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            flush_p1         <= 1'b0;
            vld_misalign_p1  <= 1'b0;
            redirect_pc_p1   <= RESET_PC;
            misalign_addr_p1 <= '0;
        end else begin
            flush_p1        <= accept_p0 & mispred_p0;
            vld_misalign_p1 <= accept_p0 & misalign_p0;
            if (accept_p0 && mispred_p0) begin
                redirect_pc_p1 <= correct_p0;
            end
            if (accept_p0 && misalign_p0) begin
                misalign_addr_p1 <= target_p0;
            end
        end
    end

    assign br.ex_ready       = ex_ready_p0;
    assign br.redirect_valid = (state_q == PEND);
    assign br.redirect_pc    = redirect_pc_p1;
    assign br.flush_o        = flush_p1;
    assign br.misalign_valid = vld_misalign_p1;
    assign br.misalign_addr  = misalign_addr_p1;

`ifdef BRANCH_REDIRECT_PERF_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Event counters; kill does not clear them, misaligned targets count as branches only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_br_cnt      <= '0;
            perf_mispred_cnt <= '0;
        end else begin
            if (accept_p0) begin
                perf_br_cnt <= sat_inc(perf_br_cnt);
            end
            if (accept_p0 && mispred_p0) begin
                perf_mispred_cnt <= sat_inc(perf_mispred_cnt);
            end
        end
    end
`endif

endmodule

// File: tb/tb_branch_redirect.sv
// tb_branch_redirect: directed scenarios followed by random traffic; a
// reference model in the driver predicts ex_ready, redirect_valid and the
// pending redirect_pc, and queues expected flush/misalign events that an
// independent monitor pops whenever the DUT pulses flush_o or misalign_valid.
module tb_branch_redirect;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic clk = 1'b0;
    logic rst_n;
    logic kill_i;

    always #5 clk = ~clk;

    branch_redirect_if #(.XLEN(XLEN)) bus ();

`ifdef BRANCH_REDIRECT_PERF_EN
    logic [31:0] perf_br_cnt;
    logic [31:0] perf_mispred_cnt;
`endif

    branch_redirect #(.XLEN(XLEN), .RESET_PC(RESET_PC)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .kill_i (kill_i),
        .br     (bus)
`ifdef BRANCH_REDIRECT_PERF_EN
        ,
        .perf_br_cnt      (perf_br_cnt),
        .perf_mispred_cnt (perf_mispred_cnt)
`endif
    );

    typedef struct {
        bit          is_mis;
        logic [31:0] addr;
    } exp_t;

    exp_t        exp_q[$];
    exp_t        mon_e;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          done  = 1'b0;

    bit          m_pend;
    logic [31:0] m_pc;
    int unsigned m_br;
    int unsigned m_mis;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, req);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, req);
        end
    endtask

    // One cycle of stimulus plus the reference model update.
    task automatic step(input bit v, input bit isb, input bit isj, input bit isjr,
                        input logic [31:0] pc, input logic [31:0] imm, input logic [31:0] rs1,
                        input bit bt, input bit pt, input logic [31:0] ptgt,
                        input bit kill, input bit rr);
        logic [31:0] tgt;
        logic [31:0] corr;
        bit          tk;
        bit          rdy;
        bit          acc;
        bit          mis;
        @(negedge clk);
        check1("redirect_valid", bus.redirect_valid, m_pend);
        if (m_pend) check("redirect_pc_hold", bus.redirect_pc, m_pc);
`ifdef BRANCH_REDIRECT_PERF_EN
        check("perf_br_cnt", perf_br_cnt, m_br);
        check("perf_mispred_cnt", perf_mispred_cnt, m_mis);
`endif
        bus.ex_valid       = v;
        bus.ex_is_branch   = isb;
        bus.ex_is_jal      = isj;
        bus.ex_is_jalr     = isjr;
        bus.ex_pc          = pc;
        bus.ex_imm         = imm;
        bus.ex_rs1         = rs1;
        bus.br_taken       = bt;
        bus.pred_taken     = pt;
        bus.pred_target    = ptgt;
        bus.redirect_ready = rr;
        kill_i             = kill;
        #1;
        rdy = !m_pend || rr;
        check1("ex_ready", bus.ex_ready, rdy);
        acc  = v && rdy && (isb || isj || isjr) && !kill;
        tgt  = isjr ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
        tk   = isj || isjr || (isb && bt);
        corr = tk ? tgt : pc + 32'd4;
        mis  = 1'b0;
        if (acc) begin
            m_br++;
            if (tk && tgt[1]) begin
                exp_q.push_back('{1'b1, tgt});
            end else if ((pt != tk) || (tk && pt && ptgt != tgt)) begin
                mis = 1'b1;
                m_mis++;
                exp_q.push_back('{1'b0, corr});
            end
        end
        if (kill) m_pend = 1'b0;
        else if (mis) begin
            m_pend = 1'b1;
            m_pc   = corr;
        end else if (m_pend && rr) m_pend = 1'b0;
    endtask

    task automatic idle(input bit rr);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, rr);
    endtask

    // Monitor: every flush or misalign pulse must match the oldest queued event.
    always @(negedge clk) begin
        if (rst_n && !done) begin
            if (bus.flush_o) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_flush: got flush with redirect_pc 0x%08h, want none", bus.redirect_pc);
                end else begin
                    mon_e = exp_q.pop_front();
                    check1("flush_expected", bus.flush_o, !mon_e.is_mis);
                    check("redirect_pc", bus.redirect_pc, mon_e.addr);
                    check1("redirect_valid_with_flush", bus.redirect_valid, 1'b1);
                end
            end
            if (bus.misalign_valid) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_misalign: got addr 0x%08h, want none", bus.misalign_addr);
                end else begin
                    mon_e = exp_q.pop_front();
                    check1("misalign_expected", bus.misalign_valid, mon_e.is_mis);
                    check("misalign_addr", bus.misalign_addr, mon_e.addr);
                    check1("no_flush_on_misalign", bus.flush_o, 1'b0);
                end
            end
        end
    end

    initial begin
        bit          v, isb, isj, isjr, bt, pt, kill, rr;
        logic [31:0] pc, imm, rs1, guess, ptgt;
        int unsigned kind;

        rst_n = 1'b0;
        kill_i = 1'b0;
        bus.ex_valid = 1'b0;  bus.ex_is_branch = 1'b0; bus.ex_is_jal = 1'b0;
        bus.ex_is_jalr = 1'b0; bus.ex_pc = '0; bus.ex_imm = '0; bus.ex_rs1 = '0;
        bus.br_taken = 1'b0;  bus.pred_taken = 1'b0; bus.pred_target = '0;
        bus.redirect_ready = 1'b0;
        m_pend = 1'b0; m_pc = RESET_PC; m_br = 0; m_mis = 0;

        #3;
        check1("reset_redirect_valid", bus.redirect_valid, 1'b0);
        check("reset_redirect_pc", bus.redirect_pc, RESET_PC);
        check1("reset_flush", bus.flush_o, 1'b0);
        check1("reset_misalign_valid", bus.misalign_valid, 1'b0);
        check("reset_misalign_addr", bus.misalign_addr, 32'h0);
        check1("reset_ex_ready", bus.ex_ready, 1'b1);
        #20;
        @(negedge clk);
        rst_n = 1'b1;

        // Not-taken BEQ, predicted not-taken: nothing happens.
        step(1, 1, 0, 0, 32'h100, 32'h20, 32'h0, 0, 0, 32'h0, 0, 1);
        // Taken BNE predicted not-taken, fetch stalls three cycles then accepts.
        step(1, 1, 0, 0, 32'h200, 32'h40, 32'h0, 1, 0, 32'h0, 0, 0);
        idle(0); idle(0); idle(0);
        idle(1);
        idle(1);
        // JALR with LSB clear: correct prediction, then wrong target.
        step(1, 0, 0, 1, 32'h400, 32'h10, 32'h1001, 0, 1, 32'h1010, 0, 1);
        step(1, 0, 0, 1, 32'h400, 32'h10, 32'h1001, 0, 1, 32'h2000, 0, 0);
        idle(1);
        // JAL to a misaligned target.
        step(1, 0, 1, 0, 32'h300, 32'h2, 32'h0, 0, 1, 32'h302, 0, 1);
        idle(1);
        idle(1);
        // Kill while pending, together with redirect_ready.
        step(1, 1, 0, 0, 32'h500, 32'h80, 32'h0, 1, 0, 32'h0, 0, 0);
        idle(0);
        step(0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0, 1, 1);
        idle(0);
        // Back-to-back mispredicts with handshake in the second accept cycle.
        step(1, 1, 0, 0, 32'h600, 32'h100, 32'h0, 1, 0, 32'h0, 0, 1);
        step(1, 0, 1, 0, 32'h800, 32'h40, 32'h0, 0, 0, 32'h0, 0, 1);
        idle(1);
        idle(1);

        // Random traffic.
        for (int i = 0; i < 600; i++) begin
            kind = $urandom_range(0, 3);
            isb  = (kind == 0);
            isj  = (kind == 1);
            isjr = (kind == 2);
            v    = ($urandom_range(0, 7) != 0);
            pc   = $urandom & 32'hFFFF_FFFC;
            imm  = ($urandom_range(0, 1) != 0) ? ($urandom & 32'h0000_0FFE)
                                               : (32'hFFFF_F000 | ($urandom & 32'h0000_0FFE));
            if ($urandom_range(0, 3) != 0) imm = imm & 32'hFFFF_FFFD;
            rs1  = $urandom;
            bt   = bit'($urandom_range(0, 1));
            pt   = bit'($urandom_range(0, 1));
            guess = isjr ? ((rs1 + imm) & 32'hFFFF_FFFE) : pc + imm;
            ptgt = ($urandom_range(0, 2) != 0) ? guess : $urandom;
            kill = ($urandom_range(0, 9) == 0);
            rr   = bit'($urandom_range(0, 1));
            step(v, isb, isj, isjr, pc, imm, rs1, bt, pt, ptgt, kill, rr);
        end

        idle(1);
        idle(1);
        idle(1);
        @(negedge clk);
        done = 1'b1;
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
